// File: rtl/vend_controller.sv
// vend_controller: coin-credit sequencer with selection, cancel, single-cycle dispense and greedy change payout.
module vend_controller #(
  parameter int PRICE_A    = 7,
  parameter int PRICE_B    = 12,
  parameter int PRICE_C    = 20,
  parameter int MAX_CREDIT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic [4:0] total,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       dispense,
  output logic [1:0] item,
  output logic       change_valid,
  output logic [3:0] change_coin,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_e;
  state_e     state_q, state_d;
  logic [4:0] total_q, total_d;
  logic [1:0] item_q, item_d;
  logic       reject_q, reject_d, insuf_q, insuf_d;
  logic [4:0] price;
  logic [5:0] sum;
  logic [3:0] greedy;
  logic       legal;
  assign legal  = coin == 4'd1 || coin == 4'd2 || coin == 4'd5 || coin == 4'd10;
  assign sum    = {1'b0, total_q} + {2'b00, coin};
  assign price  = sel == 2'd0 ? 5'(PRICE_A) : sel == 2'd1 ? 5'(PRICE_B) : 5'(PRICE_C);
  assign greedy = total_q >= 5'd10 ? 4'd10 : total_q >= 5'd5 ? 4'd5 :
                  total_q >= 5'd2 ? 4'd2 : total_q != 5'd0 ? 4'd1 : 4'd0;
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    item_d   = item_q;
    reject_d = 1'b0;
    insuf_d  = 1'b0;
    if (state_q == IDLE || state_q == COLLECT) begin
      // cancel beats selection beats coin; a losing coin is refused
      if (cancel) begin
        reject_d = coin_valid;
        if (state_q == COLLECT) state_d = CHANGE;
      end else if (sel_valid) begin
        reject_d = coin_valid;
        if (sel == 2'd3 || price > total_q) insuf_d = 1'b1;
        else begin
          total_d = total_q - price;
          item_d  = sel;
          state_d = DISPENSE;
        end
      end else if (coin_valid) begin
        if (legal && sum <= 6'(MAX_CREDIT)) begin
          total_d = sum[4:0];
          state_d = COLLECT;
        end else reject_d = 1'b1;
      end
    end else if (state_q == DISPENSE) begin
      reject_d = coin_valid;
      state_d  = total_q != 5'd0 ? CHANGE : IDLE;
    end else begin
      reject_d = coin_valid;
      total_d  = total_q - {1'b0, greedy};
      state_d  = total_d == 5'd0 ? IDLE : CHANGE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      total_q  <= 5'd0;
      item_q   <= 2'd0;
      reject_q <= 1'b0;
      insuf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      insuf_q  <= insuf_d;
    end
  end
  assign total        = total_q;
  assign item         = item_q;
  assign coin_reject  = reject_q;
  assign insufficient = insuf_q;
  assign dispense     = state_q == DISPENSE;
  assign change_valid = state_q == CHANGE;
  assign change_coin  = change_valid ? greedy : 4'd0;
  assign busy         = dispense | change_valid;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenario tests for vend_controller with hand-computed expectations.
module tb_vend_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin = 4'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic [4:0] total;
  logic       coin_reject, insufficient, dispense, change_valid, busy;
  logic [1:0] item;
  logic [3:0] change_coin;
  int tests = 0;
  int fails = 0;

  vend_controller dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .sel_valid(sel_valid),
    .sel(sel), .cancel(cancel), .total(total), .coin_reject(coin_reject),
    .insufficient(insufficient), .dispense(dispense), .item(item),
    .change_valid(change_valid), .change_coin(change_coin), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [3:0] v);
    coin_valid = 1'b1; coin = v;
    cyc();
    coin_valid = 1'b0; coin = 4'd0;
  endtask

  task automatic put_sel(input logic [1:0] s);
    sel_valid = 1'b1; sel = s;
    cyc();
    sel_valid = 1'b0; sel = 2'd0;
  endtask

  task automatic put_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (total !== 5'd0) begin fails++; $display("FAIL rst_total got=%0d exp=0", total); end
    tests++; if (busy !== 1'b0 || dispense !== 1'b0 || change_valid !== 1'b0) begin fails++; $display("FAIL rst_flags busy=%b disp=%b cv=%b exp=000", busy, dispense, change_valid); end
    tests++; if (coin_reject !== 1'b0 || insufficient !== 1'b0) begin fails++; $display("FAIL rst_pulses rej=%b ins=%b exp=00", coin_reject, insufficient); end
    tests++; if (item !== 2'd0 || change_coin !== 4'd0) begin fails++; $display("FAIL rst_item item=%0d cc=%0d exp=0/0", item, change_coin); end
    #10 rst = 1'b1;
  endtask

  task automatic test_coins();
    put_coin(4'd5);
    tests++; if (total !== 5'd5 || coin_reject !== 1'b0) begin fails++; $display("FAIL coin5 total=%0d rej=%b exp=5/0", total, coin_reject); end
    put_coin(4'd10);
    tests++; if (total !== 5'd15 || coin_reject !== 1'b0) begin fails++; $display("FAIL coin10 total=%0d rej=%b exp=15/0", total, coin_reject); end
    put_coin(4'd3);
    tests++; if (total !== 5'd15 || coin_reject !== 1'b1) begin fails++; $display("FAIL coin3 total=%0d rej=%b exp=15/1", total, coin_reject); end
    cyc();
    tests++; if (coin_reject !== 1'b0 || total !== 5'd15) begin fails++; $display("FAIL rej_pulse rej=%b total=%0d exp=0/15", coin_reject, total); end
  endtask

  task automatic test_vend();
    put_sel(2'd1);
    tests++; if (dispense !== 1'b1 || item !== 2'd1 || total !== 5'd3 || busy !== 1'b1) begin fails++; $display("FAIL vend_disp disp=%b item=%0d total=%0d busy=%b exp=1/1/3/1", dispense, item, total, busy); end
    cyc();
    tests++; if (dispense !== 1'b0 || change_valid !== 1'b1 || change_coin !== 4'd2 || total !== 5'd3) begin fails++; $display("FAIL vend_chg1 disp=%b cv=%b cc=%0d total=%0d exp=0/1/2/3", dispense, change_valid, change_coin, total); end
    cyc();
    tests++; if (change_valid !== 1'b1 || change_coin !== 4'd1 || total !== 5'd1) begin fails++; $display("FAIL vend_chg2 cv=%b cc=%0d total=%0d exp=1/1/1", change_valid, change_coin, total); end
    cyc();
    tests++; if (change_valid !== 1'b0 || busy !== 1'b0 || total !== 5'd0) begin fails++; $display("FAIL vend_idle cv=%b busy=%b total=%0d exp=0/0/0", change_valid, busy, total); end
  endtask

  task automatic test_insufficient();
    put_coin(4'd5);
    put_sel(2'd2);
    tests++; if (insufficient !== 1'b1 || total !== 5'd5 || dispense !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL insuf_c ins=%b total=%0d disp=%b busy=%b exp=1/5/0/0", insufficient, total, dispense, busy); end
    cyc();
    tests++; if (insufficient !== 1'b0 || total !== 5'd5) begin fails++; $display("FAIL insuf_pulse ins=%b total=%0d exp=0/5", insufficient, total); end
    put_coin(4'd10);
    put_sel(2'd3);
    tests++; if (insufficient !== 1'b1 || dispense !== 1'b0 || total !== 5'd15) begin fails++; $display("FAIL insuf_sel3 ins=%b disp=%b total=%0d exp=1/0/15", insufficient, dispense, total); end
  endtask

  task automatic test_cancel();
    logic [3:0] exp_cc [4] = '{4'd10, 4'd10, 4'd10, 4'd1};
    logic [4:0] exp_tot [4] = '{5'd31, 5'd21, 5'd11, 5'd1};
    put_coin(4'd10);
    put_coin(4'd5);
    tests++; if (total !== 5'd30) begin fails++; $display("FAIL cancel_setup total=%0d exp=30", total); end
    put_coin(4'd2);
    tests++; if (coin_reject !== 1'b1 || total !== 5'd30) begin fails++; $display("FAIL over_max rej=%b total=%0d exp=1/30", coin_reject, total); end
    put_coin(4'd1);
    tests++; if (coin_reject !== 1'b0 || total !== 5'd31) begin fails++; $display("FAIL at_max rej=%b total=%0d exp=0/31", coin_reject, total); end
    put_cancel();
    for (int i = 0; i < 4; i++) begin
      tests++; if (change_valid !== 1'b1 || change_coin !== exp_cc[i] || total !== exp_tot[i]) begin fails++; $display("FAIL cancel_chg%0d cv=%b cc=%0d total=%0d exp=1/%0d/%0d", i, change_valid, change_coin, total, exp_cc[i], exp_tot[i]); end
      if (i < 3) cyc();
    end
    cyc();
    tests++; if (total !== 5'd0 || busy !== 1'b0) begin fails++; $display("FAIL cancel_end total=%0d busy=%b exp=0/0", total, busy); end
  endtask

  task automatic test_collision();
    put_coin(4'd10);
    put_coin(4'd2);
    cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0; coin_valid = 1'b1; coin = 4'd5;
    cyc();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin = 4'd0;
    tests++; if (coin_reject !== 1'b1 || dispense !== 1'b0 || total !== 5'd12) begin fails++; $display("FAIL coll_rej rej=%b disp=%b total=%0d exp=1/0/12", coin_reject, dispense, total); end
    tests++; if (change_valid !== 1'b1 || change_coin !== 4'd10) begin fails++; $display("FAIL coll_chg1 cv=%b cc=%0d exp=1/10", change_valid, change_coin); end
    cyc();
    tests++; if (change_coin !== 4'd2 || total !== 5'd2 || coin_reject !== 1'b0) begin fails++; $display("FAIL coll_chg2 cc=%0d total=%0d rej=%b exp=2/2/0", change_coin, total, coin_reject); end
    cyc();
    tests++; if (busy !== 1'b0 || total !== 5'd0) begin fails++; $display("FAIL coll_end busy=%b total=%0d exp=0/0", busy, total); end
  endtask

  task automatic test_async_reset();
    put_coin(4'd5);
    put_coin(4'd1);
    put_coin(4'd2);
    put_cancel();
    tests++; if (change_valid !== 1'b1 || change_coin !== 4'd5 || total !== 5'd8) begin fails++; $display("FAIL ar_pre cv=%b cc=%0d total=%0d exp=1/5/8", change_valid, change_coin, total); end
    #2 rst = 1'b0;
    #1;
    tests++; if (total !== 5'd0 || change_valid !== 1'b0 || busy !== 1'b0 || change_coin !== 4'd0) begin fails++; $display("FAIL ar_now total=%0d cv=%b busy=%b cc=%0d exp=0/0/0/0", total, change_valid, busy, change_coin); end
    #2 rst = 1'b1;
    put_coin(4'd10);
    tests++; if (total !== 5'd10 || coin_reject !== 1'b0) begin fails++; $display("FAIL ar_after total=%0d rej=%b exp=10/0", total, coin_reject); end
  endtask

  task automatic test_busy_coin();
    put_sel(2'd0);
    tests++; if (dispense !== 1'b1 || item !== 2'd0 || total !== 5'd3) begin fails++; $display("FAIL busy_disp disp=%b item=%0d total=%0d exp=1/0/3", dispense, item, total); end
    put_coin(4'd1);
    tests++; if (coin_reject !== 1'b1 || total !== 5'd3 || change_coin !== 4'd2) begin fails++; $display("FAIL busy_coin rej=%b total=%0d cc=%0d exp=1/3/2", coin_reject, total, change_coin); end
    cyc();
    cyc();
    tests++; if (busy !== 1'b0 || total !== 5'd0) begin fails++; $display("FAIL busy_end busy=%b total=%0d exp=0/0", busy, total); end
  endtask

  task automatic test_back_to_back();
    put_coin(4'd10);
    put_coin(4'd2);
    tests++; if (total !== 5'd12) begin fails++; $display("FAIL b2b_total total=%0d exp=12", total); end
    put_sel(2'd1);
    tests++; if (dispense !== 1'b1 || item !== 2'd1 || total !== 5'd0) begin fails++; $display("FAIL exact_disp disp=%b item=%0d total=%0d exp=1/1/0", dispense, item, total); end
    cyc();
    tests++; if (busy !== 1'b0 || change_valid !== 1'b0 || dispense !== 1'b0) begin fails++; $display("FAIL exact_idle busy=%b cv=%b disp=%b exp=0/0/0", busy, change_valid, dispense); end
  endtask

  initial begin
    test_reset();
    test_coins();
    test_vend();
    test_insufficient();
    test_cancel();
    test_collision();
    test_async_reset();
    test_busy_coin();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the vending machine's coin-credit datapath. It owns the credit accumulator, validates and accumulates inserted coins, and arbitrates between coin insertion, product selection and cancel. It issues a single-cycle dispense strobe and pays out change one coin per cycle using greedy 10/5/2/1 NIS decomposition. It sits between the coin/keypad front end and the dispenser/change-hopper drivers.

## Interface
Parameters:
- PRICE_A, 7, price of item 0 in NIS
- PRICE_B, 12, price of item 1 in NIS
- PRICE_C, 20, price of item 2 in NIS
- MAX_CREDIT, 31, credit ceiling; must be ≤ 31 (5-bit total); all prices in 1..MAX_CREDIT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- coin_valid  in  1  coin present this cycle
- coin  in  4  coin value in NIS
- sel_valid  in  1  product selection strobe
- sel  in  2  0=A, 1=B, 2=C, 3=invalid
- cancel  in  1  abort and refund credit
- total  out  5  current credit, registered
- coin_reject  out  1  registered one-cycle pulse: coin refused
- insufficient  out  1  registered one-cycle pulse: selection refused
- dispense  out  1  high for exactly one cycle per vend
- item  out  2  item being dispensed; valid while dispense=1
- change_valid  out  1  a change coin is output this cycle
- change_coin  out  4  change coin value; valid while change_valid=1
- busy  out  1  high in DISPENSE or CHANGE

## Operation
- States: IDLE (total=0), COLLECT (total>0), DISPENSE, CHANGE.
- Reset (rst=0, any time, any state): state=IDLE, total=0, item=0; coin_reject, insufficient, dispense, change_valid=0; change_coin=0. Takes effect immediately, no clock needed.
- Accepted coin values: 1, 2, 5, 10. Any other value is rejected.
- Per-cycle priority in IDLE/COLLECT: cancel > sel_valid > coin_valid. A coin arriving in the same cycle as a winning cancel or sel_valid is rejected.
- Coin (IDLE/COLLECT, no cancel/sel): accepted if the value is legal and total+coin ≤ MAX_CREDIT. Then total += coin and next state=COLLECT. Otherwise coin_reject pulses and total is unchanged. Use 6-bit internal sum for the overflow check; no wrap.
- Coins presented in DISPENSE/CHANGE are always rejected.
- sel_valid in IDLE/COLLECT:
  - sel=3 or price > total: insufficient pulses; state and total unchanged.
  - Otherwise: item<=sel, total<=total−price, next state=DISPENSE.
- cancel:
  - COLLECT: next state=CHANGE, total unchanged.
  - IDLE: no effect.
  - DISPENSE/CHANGE: ignored.
- sel_valid is also ignored in DISPENSE/CHANGE.
- DISPENSE: lasts one cycle with dispense=1. Next state=CHANGE if total>0, else IDLE.
- CHANGE:
  - change_valid=1.
  - change_coin = largest of {10,5,2,1} ≤ total, combinational from the registered total.
  - Each edge: total −= change_coin.
  - When the result is 0, next state=IDLE.
- busy=1 exactly in DISPENSE/CHANGE; dispense/change_valid/busy are Moore outputs.

## Timing
- Coin sampled at edge N: total updated after edge N; coin_reject high from edge N to edge N+1.
- Selection sampled at edge N: dispense and item high N→N+1, and total already shows the remainder. First change coin appears N+1→N+2.
- Change of C NIS takes one cycle per greedy coin; for example, 18 → 10, 5, 2, 1 over 4 cycles. Return to IDLE occurs at the edge that clears the last coin.
- insufficient: one cycle, registered, same timing as coin_reject.
- Back-to-back coins on consecutive cycles are all processed; there is no dead cycle.

## Test plan
- Reset, then 5 then 10 NIS on consecutive cycles -> total 5 then 15; then coin=3 -> coin_reject one cycle, total stays 15.
- total=15, sel=1 (B=12) -> dispense=1 and item=1 for one cycle with total=3, then change 2 then 1 on consecutive cycles, then IDLE with busy=0.
- total=5, sel=2 (C=20) -> insufficient pulse, total 5, state COLLECT; sel=3 at total 15 -> insufficient, no dispense.
- total=30, coin=2 -> coin_reject (32>31), total 30; coin=1 -> total 31; cancel -> change 10, 10, 10, 1 over 4 cycles, then total 0.
- total=12, cancel+sel_valid(sel=0)+coin=5 in the same cycle -> coin_reject, no dispense, change 10 then 2.
- Drive rst=0 mid-CHANGE (total=8) -> total=0, change_valid=0, busy=0 immediately without a clock edge; coins accepted normally after release.
